// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited word reads, prefetch FIFO to the core's IR,
// and flush of wrong-path words (buffered and still in flight) on redirect.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clock_50,
  input  logic               reset,
  instr_fetch_unit_if.master imem,
  output logic [15:0]        IR,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  input  logic               halt,
  output logic [15:0]        fetch_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t                 r_state;
  logic [15:0]            r_pc;
  logic [DEPTH-1:0][15:0] r_fdata;
  logic [DEPTH-1:0][15:0] r_faddr;
  logic [DEPTH-1:0][15:0] r_aq;
  logic [AW-1:0]          r_wp, r_rp, r_aq_wp, r_aq_rp;
  logic [CW-1:0]          r_cnt, r_out, r_disc;

  logic          w_req, w_issue, w_pop, w_push, w_drop;
  logic [CW:0]   w_used;

  // Buffered words plus requests in flight never exceed DEPTH, so a return always has a slot.
  assign w_used  = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_req   = !reset && (r_state == RUN) && !redirect && (w_used < (CW+1)'(DEPTH));
  assign w_issue = w_req && imem.imem_gnt;
  assign w_pop   = ir_valid && ir_ready;
  assign w_push  = imem.imem_rvalid && !redirect && (r_disc == '0);
  assign w_drop  = imem.imem_rvalid && !redirect && (r_disc != '0);

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign ir_valid       = (r_cnt != '0);
  assign IR             = r_fdata[r_rp];
  assign fetch_pc       = r_faddr[r_rp];

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_wp    <= '0;
      r_rp    <= '0;
      r_aq_wp <= '0;
      r_aq_rp <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_disc  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fdata[i] <= '0;
        r_faddr[i] <= RESET_PC;
        r_aq[i]    <= RESET_PC;
      end
    end else begin
      r_state <= halt ? HALTED : RUN;
      r_out   <= r_out + CW'(w_issue) - CW'(imem.imem_rvalid);
      // The address side queue tracks every response, kept or dropped, so it never desyncs.
      if (w_issue) begin
        r_aq[r_aq_wp] <= r_pc;
        r_aq_wp       <= r_aq_wp + 1'b1;
      end
      if (imem.imem_rvalid) r_aq_rp <= r_aq_rp + 1'b1;
      if (redirect) begin
        r_pc   <= redirect_pc;
        r_cnt  <= '0;
        r_rp   <= r_wp;
        r_disc <= r_out - CW'(imem.imem_rvalid);
      end else begin
        if (w_issue) r_pc <= r_pc + 16'd1;
        if (w_drop)  r_disc <= r_disc - 1'b1;
        if (w_push) begin
          r_fdata[r_wp] <= imem.imem_rdata;
          r_faddr[r_wp] <= r_aq[r_aq_rp];
          r_wp          <= r_wp + 1'b1;
        end
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  a_out_uf:  assert property (@(posedge clock_50) disable iff (reset) imem.imem_rvalid |-> (r_out != '0));
  a_disc_uf: assert property (@(posedge clock_50) disable iff (reset) r_disc <= r_out);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: memory model with selectable latency, queue scoreboard on the IR handshake.
module tb_instr_fetch_unit;
  logic        clock_50, reset;
  logic [15:0] IR, fetch_pc, redirect_pc;
  logic        ir_valid, ir_ready, redirect, halt;
  logic [15:0] w_IR, w_fetch_pc;
  logic        w_valid;
  int          lat;
  int          n_tests, n_fail;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  instr_fetch_unit_if mif ();
  instr_fetch_unit_if wif ();

  instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clock_50(clock_50), .reset(reset), .imem(mif), .IR(IR), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .fetch_pc(fetch_pc));

  instr_fetch_unit #(.RESET_PC(16'hFFFF), .DEPTH(4)) u_wrap (
    .clock_50(clock_50), .reset(reset), .imem(wif), .IR(w_IR), .ir_valid(w_valid),
    .ir_ready(1'b1), .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0),
    .fetch_pc(w_fetch_pc));

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  // Main memory: response arrives 'lat' cycles after issue, data = addr ^ A500.
  logic [4:1]  mv;
  logic [15:0] ma [1:4];
  always @(posedge clock_50) begin
    if (reset) mv <= '0;
    else begin
      mv    <= {mv[3:1], mif.imem_req && mif.imem_gnt};
      ma[1] <= mif.imem_addr;
      for (int k = 4; k > 1; k--) ma[k] <= ma[k-1];
    end
  end
  assign mif.imem_gnt    = 1'b1;
  assign mif.imem_rvalid = mv[lat];
  assign mif.imem_rdata  = ma[lat] ^ 16'hA500;

  logic        wv;
  logic [15:0] wa;
  always @(posedge clock_50) begin
    if (reset) wv <= 1'b0;
    else begin
      wv <= wif.imem_req && wif.imem_gnt;
      wa <= wif.imem_addr;
    end
  end
  assign wif.imem_gnt    = 1'b1;
  assign wif.imem_rvalid = wv;
  assign wif.imem_rdata  = wa ^ 16'hA500;

  always @(negedge clock_50) begin
    if (!reset && ir_valid && ir_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: IR=%h fetch_pc=%h with nothing expected", IR, fetch_pc);
      end else begin
        e = exp_q.pop_front();
        if (IR !== (e ^ 16'hA500) || fetch_pc !== e) begin
          n_fail++;
          $display("FAIL sb_word: got IR=%h pc=%h expected IR=%h pc=%h", IR, fetch_pc, e ^ 16'hA500, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock_50);
      #1;
    end
  endtask

  task automatic load_exp(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 16'(i));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0; lat = 1;
    cyc(3);
    #1 chk("req_in_reset", mif.imem_req, 1'b0);
    // c0: first cycle out of reset
    reset = 1'b0; ir_ready = 1'b1; load_exp(16'h0000);
    #1;
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_IR", IR, 16'h0000);
    chk("rst_fetch_pc", fetch_pc, 16'h0000);
    chk("rst_req", mif.imem_req, 1'b1);
    chk("rst_addr", mif.imem_addr, 16'h0000);
    chk("wrap_addr0", wif.imem_addr, 16'hFFFF);
    chk("wrap_rst_pc", w_fetch_pc, 16'hFFFF);
    cyc(); #1;
    chk("c1_valid", ir_valid, 1'b0);
    chk("c1_addr", mif.imem_addr, 16'h0001);
    chk("wrap_addr1", wif.imem_addr, 16'h0000);
    cyc(); #1;
    chk("c2_valid", ir_valid, 1'b1);
    chk("c2_IR", IR, 16'hA500);
    chk("wrap_c2_valid", w_valid, 1'b1);
    chk("wrap_c2_IR", w_IR, 16'h5AFF);
    chk("wrap_c2_pc", w_fetch_pc, 16'hFFFF);
    cyc(); #1;
    chk("wrap_c3_IR", w_IR, 16'hA500);
    chk("wrap_c3_pc", w_fetch_pc, 16'h0000);
    cyc(); #1;
    chk("wrap_c4_valid", w_valid, 1'b1);
    chk("wrap_c4_IR", w_IR, 16'hA501);
    cyc(6);

    // Backpressure: FIFO fills to 2 and requests stop.
    ir_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i >= 3) begin
        chk("stall_req", mif.imem_req, 1'b0);
        chk("stall_valid", ir_valid, 1'b1);
      end
      cyc();
    end
    ir_ready = 1'b1;
    #1 chk("rel0_valid", ir_valid, 1'b1);
    cyc(); #1 chk("rel1_valid", ir_valid, 1'b1);
    cyc(); #1 chk("rel2_valid", ir_valid, 1'b0);
    cyc(6);

    // Halt for 5 cycles, then resume at the next sequential PC.
    halt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(); #1 chk("halt_req", mif.imem_req, 1'b0);
    end
    chk("halt_drained", ir_valid, 1'b0);
    lat = 3;
    cyc(); halt = 1'b0;
    #1 chk("halt_exit_req", mif.imem_req, 1'b0);
    cyc(); ir_ready = 1'b0;
    #1;
    chk("resume_req", mif.imem_req, 1'b1);
    chk("resume_addr", mif.imem_addr, (exp_q.size() > 0) ? exp_q[0] : 16'hDEAD);
    cyc();

    // Two requests in flight at latency 3, redirect to 0x0040.
    cyc(); redirect = 1'b1; redirect_pc = 16'h0040;
    #1 chk("redir_req", mif.imem_req, 1'b0);
    cyc(); redirect = 1'b0; load_exp(16'h0040);
    #1 chk("stale_valid", ir_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1 chk("stale_valid", ir_valid, 1'b0);
    end
    cyc(); #1;
    chk("redir_valid", ir_valid, 1'b1);
    chk("redir_IR", IR, 16'hA540);
    chk("redir_pc", fetch_pc, 16'h0040);

    // Redirect coinciding with a handshake and a returning word.
    cyc(); ir_ready = 1'b1;
    cyc(); ir_ready = 1'b0;
    cyc(2);
    cyc(); ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    #1;
    chk("hs_redir_valid", ir_valid, 1'b1);
    chk("hs_redir_IR", IR, 16'hA541);
    chk("hs_redir_req", mif.imem_req, 1'b0);
    chk("hs_redir_rvalid", mif.imem_rvalid, 1'b1);
    cyc(); redirect = 1'b0; load_exp(16'h0100);
    #1 chk("flush_empty", ir_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1 chk("flush_wait", ir_valid, 1'b0);
    end
    cyc(); #1;
    chk("redir2_IR", IR, 16'hA400);
    chk("redir2_pc", fetch_pc, 16'h0100);

    // Reset with two requests outstanding.
    cyc(3); reset = 1'b1; exp_q.delete();
    #1 chk("rst2_req", mif.imem_req, 1'b0);
    cyc(); reset = 1'b0; load_exp(16'h0000);
    #1;
    chk("rst2_valid", ir_valid, 1'b0);
    chk("rst2_IR", IR, 16'h0000);
    chk("rst2_fetch_pc", fetch_pc, 16'h0000);
    chk("rst2_addr", mif.imem_addr, 16'h0000);
    chk("rst2_req", mif.imem_req, 1'b1);
    cyc(3); #1 chk("rst2_wait", ir_valid, 1'b0);
    cyc(); #1;
    chk("rst2_first_valid", ir_valid, 1'b1);
    chk("rst2_first_IR", IR, 16'hA500);
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
